// File: rtl/mp0_pool_reader_if.sv
// Bank read bus, sweep control and pooled-result stream of the maxpool-0 reader.
// The master modport is the reader itself; the slave side is the bank set plus the next layer.
interface mp0_pool_reader_if #(
    parameter int BD = 18
);
    logic              start;
    logic [10:0]       num_words;
    logic [3*BD-1:0]   q0;
    logic [3*BD-1:0]   q1;
    logic [3*BD-1:0]   q2;
    logic [3*BD-1:0]   q3;
    logic [10:0]       rd_addr;
    logic              rd_active;
    logic [3*BD-1:0]   pool_out;
    logic              pool_valid;
    logic [10:0]       pool_idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, num_words, q0, q1, q2, q3,
        output rd_addr, rd_active, pool_out, pool_valid, pool_idx, busy, done
    );

    modport slave (
        output start, num_words, q0, q1, q2, q3,
        input  rd_addr, rd_active, pool_out, pool_valid, pool_idx, busy, done
    );
endinterface

// File: rtl/mp0_pool_reader.sv
// Sweeps one address across the four 2x2-window banks and streams the per-channel
// signed maximum of the four returned words, one window per clock.
module mp0_pool_reader #(
    parameter int BD     = 18,
    parameter int RD_LAT = 2
) (
    input logic               clk,
    input logic               reset,
    mp0_pool_reader_if.master bus
);
    localparam int W = 3 * BD;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t            state, state_nxt;
    logic [10:0]       n_lat;
    logic [11:0]       cnt;
    logic [RD_LAT-1:0] vld_sr;
    logic [10:0]       addr_sr [RD_LAT];
    logic              last_addr;
    logic              tail;
    logic [W-1:0]      max_word;
    logic [W-1:0]      pool_out;
    logic              pool_valid;
    logic [10:0]       pool_idx;

    function automatic logic signed [BD-1:0] smax(input logic signed [BD-1:0] a,
                                                  input logic signed [BD-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // 12-bit counter so the compare against n_lat-1 never wraps.
    assign last_addr = (cnt == ({1'b0, n_lat} - 12'd1));
    assign tail      = vld_sr[RD_LAT-1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (bus.start) state_nxt = (bus.num_words != 11'd0) ? READ : FINISH;
            READ:   if (last_addr) state_nxt = DRAIN;
            DRAIN:  if ((vld_sr == '0) && !pool_valid) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.rd_active = 1'b0;
        bus.done      = 1'b0;
        unique case (state)
            IDLE:    ;
            READ,
            DRAIN:   begin bus.busy = 1'b1; bus.rd_active = 1'b1; end
            FINISH:  begin bus.busy = 1'b1; bus.done = 1'b1; end
            default: ;
        endcase
    end

    // NOTE: the short address pipeline is reset too, so a sweep aborted by reset leaves no stale valids.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_lat  <= '0;
            cnt    <= '0;
            vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) addr_sr[i] <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                n_lat <= bus.num_words;
                cnt   <= '0;
            end else if (state == READ && !last_addr) begin
                cnt <= cnt + 12'd1;
            end
            vld_sr[0]  <= (state == READ);
            addr_sr[0] <= cnt[10:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    always_comb begin
        max_word = '0;
        for (int l = 0; l < 3; l++) begin
            max_word[l*BD +: BD] = smax(smax(bus.q0[l*BD +: BD], bus.q1[l*BD +: BD]),
                                        smax(bus.q2[l*BD +: BD], bus.q3[l*BD +: BD]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pool_valid <= 1'b0;
            pool_out   <= '0;
            pool_idx   <= '0;
        end else begin
            pool_valid <= tail;
            if (tail) begin
                pool_out <= max_word;
                pool_idx <= addr_sr[RD_LAT-1];
            end
        end
    end

    assign bus.rd_addr    = cnt[10:0];
    assign bus.pool_out   = pool_out;
    assign bus.pool_valid = pool_valid;
    assign bus.pool_idx   = pool_idx;
endmodule

// File: tb/tb_mp0_pool_reader.sv
// Scoreboard bench: two readers (RD_LAT 2 and 4) share one bank image; expected
// pooled words are computed from that image when each sweep is started.
module tb_mp0_pool_reader;
    localparam int BD    = 18;
    localparam int W     = 3 * BD;
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    typedef struct {
        logic [W-1:0] word;
        logic [10:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mp0_pool_reader_if #(.BD(BD)) ifa ();
    mp0_pool_reader_if #(.BD(BD)) ifb ();

    mp0_pool_reader #(.BD(BD), .RD_LAT(LAT_A)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
    mp0_pool_reader #(.BD(BD), .RD_LAT(LAT_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

    logic [W-1:0] mem [4][2048];
    logic [W-1:0] pa  [LAT_A][4];
    logic [W-1:0] pb  [LAT_B][4];

    // Bank model: registered read data, RD_LAT cycles after the address.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            pa[0][b] <= mem[b][ifa.rd_addr];
            pb[0][b] <= mem[b][ifb.rd_addr];
            for (int s = 1; s < LAT_A; s++) pa[s][b] <= pa[s-1][b];
            for (int s = 1; s < LAT_B; s++) pb[s][b] <= pb[s-1][b];
        end
    end
    assign ifa.q0 = pa[LAT_A-1][0];
    assign ifa.q1 = pa[LAT_A-1][1];
    assign ifa.q2 = pa[LAT_A-1][2];
    assign ifa.q3 = pa[LAT_A-1][3];
    assign ifb.q0 = pb[LAT_B-1][0];
    assign ifb.q1 = pb[LAT_B-1][1];
    assign ifb.q2 = pb[LAT_B-1][2];
    assign ifb.q3 = pb[LAT_B-1][3];

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int           r_first_cyc, r_nvalid, r_done_cyc, r_ndone, r_maxaddr;
    logic [W-1:0] r_first_out;
    bit           r_active, r_busy1, r_drop_ok;

    function automatic logic [W-1:0] pack3(input int a, input int b, input int c);
        return {a[BD-1:0], b[BD-1:0], c[BD-1:0]};
    endfunction

    function automatic logic [W-1:0] model(input int addr);
        logic [W-1:0] r;
        int best, v;
        r = '0;
        for (int l = 0; l < 3; l++) begin
            best = -(1 << 30);
            for (int b = 0; b < 4; b++) begin
                v = int'($signed(mem[b][addr][l*BD +: BD]));
                if (v > best) best = v;
            end
            r[l*BD +: BD] = best[BD-1:0];
        end
        return r;
    endfunction

    task automatic fill_random(input int n);
        logic [63:0] t;
        for (int a = 0; a < n; a++)
            for (int b = 0; b < 4; b++) begin
                t = {$urandom(), $urandom()};
                mem[b][a] = t[W-1:0];
            end
    endtask

    // Runs one sweep on reader A (sel=0) or B (sel=1), checking every valid against the scoreboard.
    task automatic sweep(input bit sel, input int n, input int restart_at);
        int   lat, c;
        bit   stop, v, dn, act, bsy;
        logic [W-1:0] out;
        logic [10:0]  idx, addr;
        exp_t e;
        lat = sel ? LAT_B : LAT_A;
        r_first_cyc = -1; r_nvalid = 0; r_done_cyc = -1; r_ndone = 0; r_maxaddr = 0;
        r_first_out = '0; r_active = 0; r_busy1 = 0; r_drop_ok = 0;
        for (int k = 0; k < n; k++) sb.push_back('{model(k), 11'(k)});
        @(negedge clk);
        if (sel) begin ifb.start = 1'b1; ifb.num_words = 11'(n); end
        else     begin ifa.start = 1'b1; ifa.num_words = 11'(n); end
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        c = 0;
        stop = 0;
        while (!stop) begin
            @(negedge clk);
            c++;
            if (sel) begin
                ifb.start = (c == restart_at); ifb.num_words = (c == restart_at) ? 11'd5 : ifb.num_words;
                v = ifb.pool_valid; out = ifb.pool_out; idx = ifb.pool_idx; dn = ifb.done;
                act = ifb.rd_active; bsy = ifb.busy; addr = ifb.rd_addr;
            end else begin
                ifa.start = (c == restart_at); ifa.num_words = (c == restart_at) ? 11'd5 : ifa.num_words;
                v = ifa.pool_valid; out = ifa.pool_out; idx = ifa.pool_idx; dn = ifa.done;
                act = ifa.rd_active; bsy = ifa.busy; addr = ifa.rd_addr;
            end
            if (act) begin
                r_active = 1;
                if (int'(addr) > r_maxaddr) r_maxaddr = int'(addr);
            end
            if (c == 1) r_busy1 = bsy;
            if (v) begin
                r_nvalid++;
                if (r_first_cyc < 0) begin r_first_cyc = c; r_first_out = out; end
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra cycle=%0d got idx=%0d, required no valid", c, idx);
                end else begin
                    e = sb.pop_front();
                    if (out !== e.word || idx !== e.idx) begin
                        failures++;
                        $display("FAIL sb_data cycle=%0d got %h idx=%0d, required %h idx=%0d", c, out, idx, e.word, e.idx);
                    end
                end
            end
            if (dn) begin
                r_ndone++;
                if (r_done_cyc < 0) r_done_cyc = c;
            end
            if (r_done_cyc >= 0 && c == r_done_cyc + 1) begin
                r_drop_ok = !act && !bsy;
                stop = 1;
            end
            if (!stop && c > n + lat + 20) begin
                checks++; failures++;
                $display("FAIL sweep_timeout got no done after %0d cycles, required done", c);
                stop = 1;
            end
        end
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d undelivered, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ifa.rd_addr    !== 11'd0) begin failures++; $display("FAIL rst_rd_addr got %0d required 0", ifa.rd_addr); end
        checks++; if (ifa.rd_active  !== 1'b0)  begin failures++; $display("FAIL rst_rd_active got %b required 0", ifa.rd_active); end
        checks++; if (ifa.pool_out   !== '0)    begin failures++; $display("FAIL rst_pool_out got %h required 0", ifa.pool_out); end
        checks++; if (ifa.pool_valid !== 1'b0)  begin failures++; $display("FAIL rst_pool_valid got %b required 0", ifa.pool_valid); end
        checks++; if (ifa.pool_idx   !== 11'd0) begin failures++; $display("FAIL rst_pool_idx got %0d required 0", ifa.pool_idx); end
        checks++; if (ifa.busy       !== 1'b0)  begin failures++; $display("FAIL rst_busy got %b required 0", ifa.busy); end
        checks++; if (ifa.done       !== 1'b0)  begin failures++; $display("FAIL rst_done got %b required 0", ifa.done); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        fill_random(4);
        mem[0][0] = pack3(1, 2, 3);
        mem[1][0] = pack3(5, 0, -1);
        mem[2][0] = pack3(-7, 9, 3);
        mem[3][0] = pack3(4, 4, 4);
        sweep(1'b0, 4, -1);
        checks++; if (r_first_cyc != 4) begin failures++; $display("FAIL basic_first_cycle got %0d required 4", r_first_cyc); end
        checks++; if (r_first_out !== pack3(5, 9, 4)) begin failures++; $display("FAIL basic_first_out got %h required %h", r_first_out, pack3(5, 9, 4)); end
        checks++; if (r_nvalid != 4) begin failures++; $display("FAIL basic_valids got %0d required 4", r_nvalid); end
        checks++; if (r_done_cyc != 9) begin failures++; $display("FAIL basic_done_cycle got %0d required 9", r_done_cyc); end
        checks++; if (r_ndone != 1) begin failures++; $display("FAIL basic_done_count got %0d required 1", r_ndone); end
        checks++; if (!r_busy1) begin failures++; $display("FAIL basic_busy_c1 got 0 required 1"); end
        checks++; if (!r_drop_ok) begin failures++; $display("FAIL basic_drop got busy/active high, required low after done"); end
    endtask

    task automatic test_signed();
        mem[0][0] = pack3(-131072, -5, -1);
        mem[1][0] = pack3(-2, -6, -131072);
        mem[2][0] = pack3(-131072, -5, -1);
        mem[3][0] = pack3(-2, -6, -131072);
        sweep(1'b0, 1, -1);
        checks++; if (r_first_out !== pack3(-2, -5, -1)) begin failures++; $display("FAIL signed_max got %h required %h", r_first_out, pack3(-2, -5, -1)); end
        checks++; if (r_done_cyc != 6) begin failures++; $display("FAIL signed_done_cycle got %0d required 6", r_done_cyc); end
    endtask

    task automatic test_empty();
        sweep(1'b0, 0, -1);
        checks++; if (r_done_cyc != 1) begin failures++; $display("FAIL empty_done_cycle got %0d required 1", r_done_cyc); end
        checks++; if (r_nvalid != 0) begin failures++; $display("FAIL empty_valids got %0d required 0", r_nvalid); end
        checks++; if (r_active) begin failures++; $display("FAIL empty_rd_active got 1 required 0"); end
        checks++; if (!r_busy1) begin failures++; $display("FAIL empty_busy_c1 got 0 required 1"); end
        checks++; if (!r_drop_ok) begin failures++; $display("FAIL empty_drop got busy high, required low"); end
    endtask

    task automatic test_restart();
        fill_random(8);
        sweep(1'b0, 8, 3);
        checks++; if (r_nvalid != 8) begin failures++; $display("FAIL restart_valids got %0d required 8", r_nvalid); end
        checks++; if (r_ndone != 1) begin failures++; $display("FAIL restart_done_count got %0d required 1", r_ndone); end
        checks++; if (r_done_cyc != 13) begin failures++; $display("FAIL restart_done_cycle got %0d required 13", r_done_cyc); end
        checks++; if (!r_drop_ok) begin failures++; $display("FAIL restart_drop got busy high, required idle"); end
    endtask

    task automatic test_reset_drain();
        int n_done_seen = 0;
        int n_busy_seen = 0;
        fill_random(16);
        @(negedge clk);
        ifa.start = 1'b1; ifa.num_words = 11'd16;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        for (int c = 1; c <= 18; c++) @(negedge clk);
        checks++; if (ifa.rd_active !== 1'b1 || ifa.rd_addr !== 11'd15) begin failures++; $display("FAIL drain_state got active=%b addr=%0d required 1/15", ifa.rd_active, ifa.rd_addr); end
        reset = 1'b0;
        #1;
        checks++; if (ifa.pool_valid !== 1'b0 || ifa.pool_out !== '0 || ifa.pool_idx !== 11'd0) begin failures++; $display("FAIL rst_drain_pool got v=%b out=%h idx=%0d required 0", ifa.pool_valid, ifa.pool_out, ifa.pool_idx); end
        checks++; if (ifa.rd_active !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.rd_addr !== 11'd0) begin failures++; $display("FAIL rst_drain_ctrl got act=%b busy=%b done=%b addr=%0d required 0", ifa.rd_active, ifa.busy, ifa.done, ifa.rd_addr); end
        repeat (3) begin @(negedge clk); if (ifa.done) n_done_seen++; end
        reset = 1'b1;
        repeat (10) begin @(negedge clk); if (ifa.done) n_done_seen++; if (ifa.busy) n_busy_seen++; end
        checks++; if (n_done_seen != 0) begin failures++; $display("FAIL rst_drain_done got %0d pulses required 0", n_done_seen); end
        checks++; if (n_busy_seen != 0) begin failures++; $display("FAIL rst_drain_resume got busy %0d cycles required 0", n_busy_seen); end
        fill_random(2);
        sweep(1'b0, 2, -1);
        checks++; if (r_nvalid != 2 || r_done_cyc != 7) begin failures++; $display("FAIL post_reset_sweep got valids=%0d done=%0d required 2/7", r_nvalid, r_done_cyc); end
    endtask

    task automatic test_long();
        fill_random(2047);
        sweep(1'b1, 2047, -1);
        checks++; if (r_first_cyc != 6) begin failures++; $display("FAIL long_first_cycle got %0d required 6", r_first_cyc); end
        checks++; if (r_nvalid != 2047) begin failures++; $display("FAIL long_valids got %0d required 2047", r_nvalid); end
        checks++; if (r_done_cyc != 2054) begin failures++; $display("FAIL long_done_cycle got %0d required 2054", r_done_cyc); end
        checks++; if (r_maxaddr != 2046) begin failures++; $display("FAIL long_max_addr got %0d required 2046", r_maxaddr); end
        checks++; if (r_ndone != 1 || !r_drop_ok) begin failures++; $display("FAIL long_finish got done=%0d drop=%b required 1/1", r_ndone, r_drop_ok); end
    endtask

    initial begin
        reset = 1'b1;
        ifa.start = 1'b0; ifa.num_words = '0;
        ifb.start = 1'b0; ifb.num_words = '0;
        for (int a = 0; a < 2048; a++)
            for (int b = 0; b < 4; b++) mem[b][a] = '0;
        test_reset();
        test_basic();
        test_signed();
        test_empty();
        test_restart();
        test_reset_drain();
        test_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
